uart_axis_frame_arbiter: RTL and testbench

UART_AXIS_FRAME_ARBITER -- requirements
Module: uart_axis_frame_arbiter

---
 rtl/uart_axis_frame_arbiter_if.sv | 26 ++
 rtl/uart_axis_frame_arbiter.sv | 174 +++++++++++++++++
 tb/tb_uart_axis_frame_arbiter.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_axis_frame_arbiter_if.sv
// AXI-Stream bundle between the upload channels and the merged UART TX stream.
// The slave modport is the arbiter's view; the master modport is the environment
// (per-channel sources plus the downstream sink).
interface uart_axis_frame_arbiter_if #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned DATA_W = 8
);
  logic [NUM_CH*DATA_W-1:0] s_axis_tdata;
  logic [NUM_CH-1:0]        s_axis_tvalid;
  logic [NUM_CH-1:0]        s_axis_tlast;
  logic [NUM_CH-1:0]        s_axis_tready;
  logic [DATA_W-1:0]        m_axis_tdata;
  logic                     m_axis_tvalid;
  logic                     m_axis_tlast;
  logic                     m_axis_tready;

  modport slave (
    input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
    output s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast
  );

  modport master (
    output s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
    input  s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast
  );
endinterface

// File: rtl/uart_axis_frame_arbiter.sv
// Round-robin arbiter that grants one upload channel at a time to the UART TX
// stream for a requested number of frames, with an idle-cycle abort timeout.
module uart_axis_frame_arbiter #(
  parameter int unsigned NUM_CH   = 4,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned FRAMES_W = 4,
  parameter int unsigned TIMEOUT  = 1024,
  localparam int unsigned CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic [NUM_CH-1:0]            upload_req,
  input  logic [NUM_CH*FRAMES_W-1:0]   upload_frames,
  output logic [NUM_CH-1:0]            upload_busy,
  output logic [NUM_CH-1:0]            upload_done,
  output logic [NUM_CH-1:0]            upload_err,
  output logic                         skip_arb,
  uart_axis_frame_arbiter_if.slave     axis,
  output logic [CH_W-1:0]              m_axis_tsel
);

  localparam int unsigned TO_W     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

  typedef enum logic {ST_IDLE, ST_XFER} state_t;

  state_t              r_state, w_state_nxt;
  logic [NUM_CH-1:0]   r_pending, w_pending_nxt;
  logic [CH_W-1:0]     r_last_grant, w_last_grant_nxt;
  logic [FRAMES_W-1:0] r_target, w_target_nxt;
  logic [FRAMES_W-1:0] r_frame_cnt, w_frame_cnt_nxt;
  logic [TO_W-1:0]     r_to_cnt, w_to_cnt_nxt;
  logic [NUM_CH-1:0]   r_done, w_done_nxt;
  logic [NUM_CH-1:0]   r_err, w_err_nxt;

  logic [NUM_CH-1:0]   w_cand;
  logic                w_rr_found;
  logic [CH_W-1:0]     w_rr_idx;
  logic [FRAMES_W-1:0] w_rr_frames;
  logic [NUM_CH-1:0]   w_rr_onehot;
  logic [NUM_CH-1:0]   w_g_onehot;
  logic                w_xfer;
  logic [DATA_W-1:0]   w_sel_tdata;
  logic                w_sel_tvalid;
  logic                w_sel_tlast;
  logic                w_beat;
  logic                w_frame_end;
  logic                w_last_frame;
  logic                w_timeout;

  assign w_xfer      = (r_state == ST_XFER);
  assign w_cand      = r_pending | upload_req;
  assign w_g_onehot  = NUM_CH'(1) << r_last_grant;
  assign w_rr_onehot = NUM_CH'(1) << w_rr_idx;

  // Round-robin search: first candidate above last_grant, wrapping around.
  always_comb begin
    int unsigned v_idx;
    v_idx       = 0;
    w_rr_found  = 1'b0;
    w_rr_idx    = '0;
    w_rr_frames = '0;
    for (int unsigned k = 1; k <= NUM_CH; k++) begin
      v_idx = 32'(r_last_grant) + k;
      if (v_idx >= NUM_CH) v_idx = v_idx - NUM_CH;
      if (!w_rr_found && w_cand[v_idx]) begin
        w_rr_found  = 1'b1;
        w_rr_idx    = CH_W'(v_idx);
        w_rr_frames = upload_frames[v_idx*FRAMES_W +: FRAMES_W];
      end
    end
  end

  // Select the granted channel's stream signals.
  always_comb begin
    w_sel_tdata  = '0;
    w_sel_tvalid = 1'b0;
    w_sel_tlast  = 1'b0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (r_last_grant == CH_W'(i)) begin
        w_sel_tdata  = axis.s_axis_tdata[i*DATA_W +: DATA_W];
        w_sel_tvalid = axis.s_axis_tvalid[i];
        w_sel_tlast  = axis.s_axis_tlast[i];
      end
    end
  end

  assign w_beat       = w_xfer & w_sel_tvalid & axis.m_axis_tready;
  assign w_frame_end  = w_beat & w_sel_tlast;
  assign w_last_frame = w_frame_end &
                        (((FRAMES_W+1)'(r_frame_cnt) + 1'b1) == (FRAMES_W+1)'(r_target));
  assign w_timeout    = (TIMEOUT != 0) && w_xfer && !w_beat && (r_to_cnt == TO_LAST);

  assign axis.m_axis_tdata  = w_sel_tdata;
  assign axis.m_axis_tvalid = w_xfer & w_sel_tvalid;
  assign axis.m_axis_tlast  = w_xfer & w_sel_tlast;
  assign axis.s_axis_tready = w_xfer ? (w_g_onehot & {NUM_CH{axis.m_axis_tready}}) : '0;

  assign upload_busy = w_xfer ? w_g_onehot : '0;
  assign upload_done = r_done;
  assign upload_err  = r_err;
  assign skip_arb    = !w_xfer;
  assign m_axis_tsel = r_last_grant;

  // Next-state: arbitration in IDLE, frame/timeout tracking in XFER.
  always_comb begin
    w_state_nxt      = r_state;
    w_pending_nxt    = r_pending;
    w_last_grant_nxt = r_last_grant;
    w_target_nxt     = r_target;
    w_frame_cnt_nxt  = r_frame_cnt;
    w_to_cnt_nxt     = r_to_cnt;
    w_done_nxt       = '0;
    w_err_nxt        = '0;
    case (r_state)
      ST_IDLE: begin
        w_pending_nxt = w_cand;
        if (w_rr_found) begin
          w_state_nxt      = ST_XFER;
          w_last_grant_nxt = w_rr_idx;
          w_pending_nxt    = w_cand & ~w_rr_onehot;
          w_target_nxt     = (w_rr_frames == '0) ? FRAMES_W'(1) : w_rr_frames;
          w_frame_cnt_nxt  = '0;
          w_to_cnt_nxt     = '0;
        end
      end
      ST_XFER: begin
        // Requests on the granted channel are dropped, not queued.
        w_pending_nxt = r_pending | (upload_req & ~w_g_onehot);
        // Completion is tested first so it wins over a coincident timeout.
        if (w_last_frame) begin
          w_state_nxt = ST_IDLE;
          w_done_nxt  = w_g_onehot;
        end else if (w_timeout) begin
          w_state_nxt = ST_IDLE;
          w_err_nxt   = w_g_onehot;
        end else begin
          if (w_frame_end) w_frame_cnt_nxt = r_frame_cnt + 1'b1;
          w_to_cnt_nxt = w_beat ? '0 : r_to_cnt + 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Arbitration and transfer bookkeeping registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_pending    <= '0;
      r_last_grant <= LAST_CH;
      r_target     <= '0;
      r_frame_cnt  <= '0;
      r_to_cnt     <= '0;
      r_done       <= '0;
      r_err        <= '0;
    end else begin
      r_pending    <= w_pending_nxt;
      r_last_grant <= w_last_grant_nxt;
      r_target     <= w_target_nxt;
      r_frame_cnt  <= w_frame_cnt_nxt;
      r_to_cnt     <= w_to_cnt_nxt;
      r_done       <= w_done_nxt;
      r_err        <= w_err_nxt;
    end
  end

endmodule

// File: tb/tb_uart_axis_frame_arbiter.sv
// Self-checking bench: directed scenarios plus randomized traffic, compared
// every cycle against a transaction-level model of the arbiter.
module tb_uart_axis_frame_arbiter;

  localparam int unsigned NUM_CH   = 4;
  localparam int unsigned DATA_W   = 8;
  localparam int unsigned FRAMES_W = 4;
  localparam int unsigned TIMEOUT  = 16;
  localparam int unsigned CH_W     = 2;

  logic                       clk = 1'b0;
  logic                       rstn;
  logic [NUM_CH-1:0]          upload_req;
  logic [NUM_CH*FRAMES_W-1:0] upload_frames;
  logic [NUM_CH-1:0]          upload_busy;
  logic [NUM_CH-1:0]          upload_done;
  logic [NUM_CH-1:0]          upload_err;
  logic                       skip_arb;
  logic [CH_W-1:0]            m_axis_tsel;

  uart_axis_frame_arbiter_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) axis_bus ();

  uart_axis_frame_arbiter #(
    .NUM_CH  (NUM_CH),
    .DATA_W  (DATA_W),
    .FRAMES_W(FRAMES_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .upload_req   (upload_req),
    .upload_frames(upload_frames),
    .upload_busy  (upload_busy),
    .upload_done  (upload_done),
    .upload_err   (upload_err),
    .skip_arb     (skip_arb),
    .axis         (axis_bus),
    .m_axis_tsel  (m_axis_tsel)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", tag, $time, obs, exp);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  int        m_cur;                 // granted channel, -1 when idle
  int        m_last;                // last granted channel
  int        m_target, m_fcnt, m_idle;
  bit [3:0]  m_pend, m_done, m_err;

  // source-side frame shaping (stimulus only)
  int        src_len [NUM_CH];
  int        src_pos [NUM_CH];
  bit        rand_len;

  // grant monitor
  logic [NUM_CH-1:0] prev_busy;
  int                grants[$];

  task automatic model_reset();
    m_cur = -1; m_last = NUM_CH - 1; m_pend = '0; m_done = '0; m_err = '0;
    m_target = 1; m_fcnt = 0; m_idle = 0;
    for (int c = 0; c < NUM_CH; c++) src_pos[c] = 0;
  endtask

  task automatic model_step();
    bit [3:0] cand;
    int       g;
    int       t;
    bit       beat;
    m_done = '0;
    m_err  = '0;
    if (m_cur < 0) begin
      cand = m_pend | upload_req;
      if (cand != 0) begin
        g = -1;
        for (int k = 1; k <= NUM_CH; k++) begin
          if (g < 0 && cand[(m_last + k) % NUM_CH]) g = (m_last + k) % NUM_CH;
        end
        t = int'(upload_frames[g*FRAMES_W +: FRAMES_W]);
        m_target = (t == 0) ? 1 : t;
        m_fcnt = 0; m_idle = 0;
        m_cur = g; m_last = g;
        cand[g] = 1'b0;
      end
      m_pend = cand;
    end else begin
      for (int c = 0; c < NUM_CH; c++)
        if (c != m_cur && upload_req[c]) m_pend[c] = 1'b1;
      beat = axis_bus.s_axis_tvalid[m_cur] && axis_bus.m_axis_tready;
      if (beat) begin
        m_idle = 0;
        if (src_pos[m_cur] == src_len[m_cur] - 1) begin
          src_pos[m_cur] = 0;
          if (rand_len) src_len[m_cur] = $urandom_range(4, 1);
        end else begin
          src_pos[m_cur]++;
        end
        if (axis_bus.s_axis_tlast[m_cur]) begin
          m_fcnt++;
          if (m_fcnt == m_target) begin
            m_done[m_cur] = 1'b1;
            m_cur = -1;
          end
        end
      end else begin
        m_idle++;
        if (TIMEOUT != 0 && m_idle == TIMEOUT) begin
          m_err[m_cur] = 1'b1;
          m_cur = -1;
        end
      end
    end
  endtask

  task automatic compare();
    check_eq("busy", 32'(upload_busy), (m_cur >= 0) ? (32'd1 << m_cur) : 32'd0);
    check_eq("done", 32'(upload_done), 32'(m_done));
    check_eq("err",  32'(upload_err),  32'(m_err));
    check_eq("skip_arb", 32'(skip_arb), (m_cur < 0) ? 32'd1 : 32'd0);
    check_eq("tsel", 32'(m_axis_tsel), 32'(m_last));
    if (m_cur >= 0) begin
      check_eq("m_tvalid", 32'(axis_bus.m_axis_tvalid), 32'(axis_bus.s_axis_tvalid[m_cur]));
      check_eq("m_tlast",  32'(axis_bus.m_axis_tlast),  32'(axis_bus.s_axis_tlast[m_cur]));
      check_eq("m_tdata",  32'(axis_bus.m_axis_tdata),
               32'(axis_bus.s_axis_tdata[m_cur*DATA_W +: DATA_W]));
      check_eq("s_tready", 32'(axis_bus.s_axis_tready),
               axis_bus.m_axis_tready ? (32'd1 << m_cur) : 32'd0);
    end else begin
      check_eq("m_tvalid_idle", 32'(axis_bus.m_axis_tvalid), 32'd0);
      check_eq("m_tlast_idle",  32'(axis_bus.m_axis_tlast),  32'd0);
      check_eq("s_tready_idle", 32'(axis_bus.s_axis_tready), 32'd0);
    end
  endtask

  // ---------------- stimulus ----------------
  // rpct < 0 toggles m_axis_tready each cycle.
  task automatic set_src(input int vpct, input int rpct);
    for (int c = 0; c < NUM_CH; c++) begin
      axis_bus.s_axis_tvalid[c] = ($urandom_range(99, 0) < vpct);
      axis_bus.s_axis_tlast[c]  = (src_pos[c] == src_len[c] - 1);
      axis_bus.s_axis_tdata[c*DATA_W +: DATA_W] = DATA_W'($urandom);
    end
    if (rpct < 0) axis_bus.m_axis_tready = ~axis_bus.m_axis_tready;
    else          axis_bus.m_axis_tready = ($urandom_range(99, 0) < rpct);
  endtask

  task automatic cycle(input int vpct, input int rpct);
    set_src(vpct, rpct);
    @(negedge clk);
    if (!rstn) model_reset();
    compare();
    if (rstn) model_step();
    if (upload_busy != 0 && prev_busy == 0) begin
      for (int c = 0; c < NUM_CH; c++) if (upload_busy[c]) grants.push_back(c);
    end
    prev_busy = upload_busy;
    @(posedge clk);
    #1;
    upload_req = '0;
  endtask

  task automatic set_frames(input int ch, input int n);
    upload_frames[ch*FRAMES_W +: FRAMES_W] = FRAMES_W'(n);
  endtask

  int busy_cnt, err_seen, done_seen, stray;

  initial begin
    rstn = 1'b0;
    upload_req = '0;
    upload_frames = '0;
    axis_bus.s_axis_tdata  = '0;
    axis_bus.s_axis_tvalid = '0;
    axis_bus.s_axis_tlast  = '0;
    axis_bus.m_axis_tready = 1'b0;
    rand_len = 1'b0;
    prev_busy = '0;
    for (int c = 0; c < NUM_CH; c++) begin src_len[c] = 3; src_pos[c] = 0; end
    model_reset();
    #1;

    // Reset values
    repeat (3) cycle(100, 100);
    rstn = 1'b1;
    repeat (2) cycle(0, 100);

    // Ch0: two 3-beat frames, ready always high
    set_frames(0, 2);
    upload_req = 4'b0001;
    repeat (10) cycle(100, 100);

    // Simultaneous requests on ch1..ch3: served 1, 2, 3
    for (int c = 0; c < NUM_CH; c++) begin src_len[c] = 1; src_pos[c] = 0; end
    set_frames(1, 1); set_frames(2, 1); set_frames(3, 1);
    grants.delete();
    upload_req = 4'b1110;
    repeat (12) cycle(100, 100);
    check_eq("grant_count", 32'(grants.size()), 32'd3);
    if (grants.size() == 3) begin
      check_eq("grant_order0", 32'(grants[0]), 32'd1);
      check_eq("grant_order1", 32'(grants[1]), 32'd2);
      check_eq("grant_order2", 32'(grants[2]), 32'd3);
    end

    // frames = 0 on ch2 behaves as a single frame
    set_frames(2, 0);
    upload_req = 4'b0100;
    repeat (5) cycle(100, 100);

    // Timeout on ch1 with tvalid held low
    set_frames(1, 1);
    upload_req = 4'b0010;
    busy_cnt = 0; err_seen = 0; done_seen = 0;
    for (int i = 0; i < 30; i++) begin
      cycle(0, 100);
      if (upload_busy[1]) busy_cnt++;
      if (upload_err[1])  err_seen++;
      if (upload_done != 0) done_seen++;
    end
    check_eq("timeout_busy_cycles", 32'(busy_cnt), 32'(TIMEOUT));
    check_eq("timeout_err_pulses", 32'(err_seen), 32'd1);
    check_eq("timeout_no_done", 32'(done_seen), 32'd0);

    // Toggling downstream ready across a 4-beat frame on ch0
    for (int c = 0; c < NUM_CH; c++) begin src_len[c] = 4; src_pos[c] = 0; end
    set_frames(0, 1);
    upload_req = 4'b0001;
    repeat (14) cycle(100, -1);

    // Reset mid-frame with ch3 pending: nothing granted after release
    set_frames(0, 3);
    upload_req = 4'b0001;
    repeat (3) cycle(100, 100);
    upload_req = 4'b1000;
    cycle(100, 100);
    cycle(100, 100);
    rstn = 1'b0;
    cycle(100, 100);
    check_eq("rst_busy", 32'(upload_busy), 32'd0);
    check_eq("rst_skip", 32'(skip_arb), 32'd1);
    check_eq("rst_tsel", 32'(m_axis_tsel), 32'(NUM_CH - 1));
    cycle(100, 100);
    rstn = 1'b1;
    stray = 0;
    for (int i = 0; i < 8; i++) begin
      cycle(100, 100);
      if (upload_busy != 0 || upload_done != 0 || upload_err != 0) stray++;
    end
    check_eq("no_grant_after_reset", 32'(stray), 32'd0);

    // Randomized traffic with idle windows (timeouts) and occasional resets
    rand_len = 1'b1;
    for (int w = 0; w < 20; w++) begin
      int vp, rp;
      case ($urandom_range(3, 0))
        0:       vp = 0;
        1:       vp = 30;
        2:       vp = 80;
        default: vp = 100;
      endcase
      rp = ($urandom_range(1, 0) != 0) ? 100 : 50;
      for (int i = 0; i < 80; i++) begin
        for (int c = 0; c < NUM_CH; c++) begin
          upload_req[c] = ($urandom_range(99, 0) < 6);
          set_frames(c, int'($urandom_range(3, 0)));
        end
        rstn = ($urandom_range(399, 0) != 0);
        cycle(vp, rp);
      end
    end
    rstn = 1'b1;
    repeat (4) cycle(100, 100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
